// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending controller.
package irq_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned ID_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Clear mask for the line whose index is being accepted.
  function automatic logic [N_LINES-1:0] onehot_to_mask(input logic [ID_W-1:0] id);
    onehot_to_mask = N_LINES'(1) << id;
  endfunction

endpackage

// File: rtl/pending_pri_enc.sv
// Combinational priority encoder: highest set bit of sel wins.
module pending_pri_enc #(
  parameter int unsigned N   = 8,
  parameter int unsigned IDW = 3
) (
  input  logic [N-1:0]   sel,
  output logic [IDW-1:0] index_c,
  output logic           any_c
);

  always_comb begin
    index_c = '0;
    any_c   = 1'b0;
    // Ascending scan, so later (higher) hits overwrite lower ones.
    for (int i = 0; i < int'(N); i++) begin
      if (sel[i]) begin
        index_c = IDW'(i);
        any_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky request capture with highest-index-first valid/ready offer of line ids.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N    = N_LINES,
  parameter int unsigned IDW  = ID_W,
  parameter bit          EDGE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_in,
  input  logic [N-1:0]   mask,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  input  logic           out_ready,
  output logic [N-1:0]   pending,
  output logic           overflow,
  input  logic           clr_overflow
);

  state_e         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           overflow_q, overflow_d;
  logic [N-1:0]   req_prev_q, req_prev_d;

  logic [N-1:0]   ev;
  logic [N-1:0]   clr;
  logic [N-1:0]   sel;
  logic [IDW-1:0] sel_idx;
  logic           sel_any;
  logic           accept;

  assign sel = pending_q & mask;

  pending_pri_enc #(
    .N   (N),
    .IDW (IDW)
  ) u_pri_enc (
    .sel     (sel),
    .index_c (sel_idx),
    .any_c   (sel_any)
  );

  // Event capture, pending/overflow update and offer FSM.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    req_prev_d  = req_in;

    accept = out_valid_q & out_ready;
    ev     = EDGE ? (req_in & ~req_prev_q) : req_in;
    clr    = accept ? N'(onehot_to_mask(ID_W'(out_id_q))) : '0;

    // Set wins over clear on both the pending bits and overflow.
    pending_d  = (pending_q & ~clr) | ev;
    overflow_d = (EDGE && ((ev & pending_q & ~clr) != '0)) ? 1'b1
               : (overflow_q & ~clr_overflow);

    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          out_id_d    = sel_idx;
          out_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        // Offer is held until accepted; never retracted.
        if (accept) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      req_prev_q  <= '1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      req_prev_q  <= req_prev_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: edge-mode and level-mode instances against a reference model.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_s   [2];
  logic [7:0] mask_s  [2];
  logic       ready_s [2];
  logic       clro_s  [2];
  logic       val_o   [2];
  logic [2:0] id_o    [2];
  logic [7:0] pend_o  [2];
  logic       ovf_o   [2];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Reference model state, one slot per instance.
  bit [7:0] m_prev [2];
  bit [7:0] m_pend [2];
  bit       m_val  [2];
  bit [2:0] m_id   [2];
  bit       m_ovf  [2];
  bit       m_edge [2];

  irq_pending_ctrl #(.EDGE(1'b1)) u_dut_edge (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_s[0]),
    .mask         (mask_s[0]),
    .out_valid    (val_o[0]),
    .out_id       (id_o[0]),
    .out_ready    (ready_s[0]),
    .pending      (pend_o[0]),
    .overflow     (ovf_o[0]),
    .clr_overflow (clro_s[0])
  );

  irq_pending_ctrl #(.EDGE(1'b0)) u_dut_level (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_s[1]),
    .mask         (mask_s[1]),
    .out_valid    (val_o[1]),
    .out_id       (id_o[1]),
    .out_ready    (ready_s[1]),
    .pending      (pend_o[1]),
    .overflow     (ovf_o[1]),
    .clr_overflow (clro_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int highest(input bit [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = 8'hFF;
      m_pend[k] = 8'h00;
      m_val[k]  = 1'b0;
      m_id[k]   = 3'd0;
      m_ovf[k]  = 1'b0;
    end
  endtask

  // One rising edge of the reference, from the current inputs.
  task automatic model_step();
    bit [7:0] ev, clr, sel;
    bit       acc;
    for (int k = 0; k < 2; k++) begin
      acc = m_val[k] && ready_s[k];
      ev  = m_edge[k] ? (req_s[k] & ~m_prev[k]) : req_s[k];
      clr = acc ? (8'h01 << m_id[k]) : 8'h00;
      if (m_edge[k] && ((ev & m_pend[k] & ~clr) != 0)) m_ovf[k] = 1'b1;
      else if (clro_s[k]) m_ovf[k] = 1'b0;
      if (!m_val[k]) begin
        sel = m_pend[k] & mask_s[k];
        if (sel != 0) begin
          m_id[k]  = 3'(highest(sel));
          m_val[k] = 1'b1;
        end
      end else if (acc) begin
        m_val[k] = 1'b0;
      end
      m_pend[k] = (m_pend[k] & ~clr) | ev;
      m_prev[k] = req_s[k];
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.out_valid", k), 8'(val_o[k]), 8'(m_val[k]));
      check($sformatf("u%0d.out_id", k), 8'(id_o[k]), 8'(m_id[k]));
      check($sformatf("u%0d.pending", k), pend_o[k], m_pend[k]);
      check($sformatf("u%0d.overflow", k), 8'(ovf_o[k]), 8'(m_ovf[k]));
    end
  endtask

  // Advance one clock, then sample 1 time unit after the edge.
  task automatic cyc();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    m_edge[0] = 1'b1;
    m_edge[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 8'h00; mask_s[k] = 8'hFF; ready_s[k] = 1'b0; clro_s[k] = 1'b0;
    end
    req_s[0] = 8'h81;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset.valid", 8'(val_o[0]), 8'h00);
    check("reset.pending", pend_o[0], 8'h00);
    cyc(); cyc();
    rst_n = 1'b1;

    // Lines already high at release are not edges.
    cyc(); cyc(); cyc();
    check("held81.pending", pend_o[0], 8'h00);
    check("held81.valid", 8'(val_o[0]), 8'h00);

    // Pulse 0x24: id 5 then, after a bubble, id 2.
    req_s[0] = 8'h24; cyc();
    check("p24.pending", pend_o[0], 8'h24);
    check("p24.t1_valid", 8'(val_o[0]), 8'h00);
    req_s[0] = 8'h00; ready_s[0] = 1'b1; cyc();
    check("p24.t2_valid", 8'(val_o[0]), 8'h01);
    check("p24.t2_id", 8'(id_o[0]), 8'h05);
    cyc();
    check("p24.bubble_valid", 8'(val_o[0]), 8'h00);
    check("p24.after5", pend_o[0], 8'h04);
    cyc();
    check("p24.id2", 8'(id_o[0]), 8'h02);
    check("p24.id2_valid", 8'(val_o[0]), 8'h01);
    cyc();
    check("p24.final_pending", pend_o[0], 8'h00);

    // Held offer survives higher event and mask drop.
    ready_s[0] = 1'b0; req_s[0] = 8'h08; cyc();
    req_s[0] = 8'h00; cyc();
    req_s[0] = 8'h80; cyc();
    req_s[0] = 8'h00; mask_s[0] = 8'h00; cyc(); cyc();
    check("hold.valid", 8'(val_o[0]), 8'h01);
    check("hold.id", 8'(id_o[0]), 8'h03);
    check("hold.pending", pend_o[0], 8'h88);
    ready_s[0] = 1'b1; cyc(); cyc(); cyc();
    check("masked.valid", 8'(val_o[0]), 8'h00);
    check("masked.pending", pend_o[0], 8'h80);
    mask_s[0] = 8'hFF; cyc(); cyc();
    check("unmask.pending", pend_o[0], 8'h00);

    // Event on line 3 in its own accept cycle.
    ready_s[0] = 1'b0; req_s[0] = 8'h08; cyc();
    req_s[0] = 8'h00; cyc();
    req_s[0] = 8'h08; ready_s[0] = 1'b1; cyc();
    check("same.pending", pend_o[0], 8'h08);
    check("same.overflow", 8'(ovf_o[0]), 8'h00);
    req_s[0] = 8'h00; ready_s[0] = 1'b0; cyc();
    check("same.reoffer_id", 8'(id_o[0]), 8'h03);
    check("same.reoffer_valid", 8'(val_o[0]), 8'h01);
    ready_s[0] = 1'b1; cyc();

    // Overflow set, clear, and set-beats-clear.
    ready_s[0] = 1'b0; req_s[0] = 8'h02; cyc();
    req_s[0] = 8'h00; cyc();
    req_s[0] = 8'h02; cyc();
    check("ovf.set", 8'(ovf_o[0]), 8'h01);
    req_s[0] = 8'h00; clro_s[0] = 1'b1; cyc();
    check("ovf.clear", 8'(ovf_o[0]), 8'h00);
    req_s[0] = 8'h02; cyc();
    check("ovf.set_wins", 8'(ovf_o[0]), 8'h01);
    req_s[0] = 8'h00; clro_s[0] = 1'b0; ready_s[0] = 1'b1; cyc(); cyc();

    // Level mode: held line 4 re-offered every two cycles.
    req_s[1] = 8'h10; ready_s[1] = 1'b1; cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lvl.valid%0d", i), 8'(val_o[1]), 8'h01);
      check($sformatf("lvl.id%0d", i), 8'(id_o[1]), 8'h04);
      cyc();
      check($sformatf("lvl.bubble%0d", i), 8'(val_o[1]), 8'h00);
      cyc();
    end
    check("lvl.overflow", 8'(ovf_o[1]), 8'h00);
    ready_s[1] = 1'b0; cyc();
    check("lvl.pre_reset_valid", 8'(val_o[1]), 8'h01);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset.valid", 8'(val_o[1]), 8'h00);
    check("midreset.pending", pend_o[1], 8'h00);
    req_s[1] = 8'h00; cyc();
    rst_n = 1'b1;
    cyc();

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        req_s[k]   = 8'($urandom) & 8'($urandom) & 8'($urandom);
        mask_s[k]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        ready_s[k] = ($urandom_range(0, 2) != 0);
        clro_s[k]  = ($urandom_range(0, 7) == 0);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
Captures interrupt/request events on 8 lines into a sticky pending register. It selects the highest-index unmasked pending line and offers its 3-bit index downstream through a valid/ready handshake. The serviced bit is cleared only when the consumer accepts. The block sits directly upstream of the team's combinational priority-encode stage and replaces bare level inputs with held, acknowledged requests.

Parameters:
N, 8, number of request lines
IDW, 3, index width; must equal clog2(N)
EDGE, 1, 1 = capture rising edges of req_in; 0 = capture levels

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_in  in  N  request lines, synchronous to clk
mask  in  N  1 = line eligible for selection; pending still records masked lines
out_valid  out  1  offered index valid
out_id  out  IDW  index of offered line, highest unmasked pending index
out_ready  in  1  consumer accepts when out_valid && out_ready
pending  out  N  current pending register
overflow  out  1  sticky: an event arrived on an already-pending line
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (async assert, sync release) drives outputs and state as follows:
  - pending=0, out_valid=0, out_id=0, overflow=0, state=IDLE.
  - req_prev = all ones, so lines already high at reset release are not captured as edges.
- Event vector:
  - EDGE=1: ev = req_in & ~req_prev.
  - EDGE=0: ev = req_in.
  - req_prev <= req_in every cycle.
- Pending update: pending <= (pending & ~clr) | ev.
  - clr = one-hot(out_id) on an accept cycle, else 0.
  - Set wins over clear, so an event on the line being accepted in the same cycle stays pending.
- Overflow:
  - Set when EDGE=1 and (ev & pending & ~clr) != 0.
  - clr_overflow clears it; a set in the same cycle wins over the clear.
  - Never set when EDGE=0.
- Selection: sel = pending & mask. Index = highest set bit of sel.
- FSM, two states:
  - IDLE: out_valid=0. If sel != 0, register out_id = index, out_valid <= 1, go to OFFER. Otherwise stay.
  - OFFER: out_valid=1. out_id and out_valid are held stable until accepted, regardless of mask changes or new higher-priority events (no retraction). On out_valid && out_ready: clear pending[out_id], out_valid <= 0, go to IDLE.
- Latency:
  - Edge sampled at cycle t → pending bit visible at t+1 → out_valid at t+2.
  - After an accept there is one IDLE bubble cycle before the next offer. Maximum throughput is one accept per 2 cycles.
- out_ready asserted while out_valid=0 has no effect.
- If a line's mask bit is cleared while it is pending, the bit is retained and is offered once unmasked.
- Reset asserted mid-offer: the offer is dropped and pending is lost. The consumer must treat reset as a flush.

Decomposition:
- Shared package irq_pkg holds:
  - N_LINES=8 and ID_W=3;
  - state enum {IDLE, OFFER};
  - a function onehot_to_mask(id) used for clr.
- One sub-module: pending_pri_enc. It is purely combinational: sel[N] → index[IDW] plus any flag, with highest index winning. Instantiate it once for the selection path.

Test Plan:
- Reset release with req_in=8'h81 held high, EDGE=1 → no capture, pending=0, out_valid stays 0.
- Pulse req_in=8'h24 for one cycle, mask=8'hFF, out_ready=1 → out_valid at t+2 with out_id=5. The accept clears bit 5. After one bubble, out_id=2 is offered and accepted; pending ends at 0.
- Offer of id 3 with out_ready=0, then pulse line 7 and set mask=0 → out_id stays 3 and out_valid stays 1 until out_ready=1. Then pending=8'h80 remains; because mask=0, nothing further is offered.
- Event on line 3 in the same cycle that id 3 is accepted → pending[3]=1 afterward, id 3 is re-offered, overflow=0.
- Second rising edge on line 1 while pending[1]=1 → overflow=1. Assert clr_overflow → 0 next cycle. Assert clr_overflow together with a new overflow event → stays 1.
- EDGE=0, req_in=8'h10 held, out_ready=1 → id 4 offered every 2 cycles while held, overflow stays 0. Assert rst_n low during an offer → out_valid=0 and pending=0 immediately.
